// File: rtl/phase_sched_pkg.sv
// Shared encodings for the traffic phase scheduler: FSM states, phase codes,
// requester indices and small index/phase conversion helpers.
package phase_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARB       = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_CLEAR     = 3'd4
    } state_e;

    localparam logic [1:0] PH_NORMAL = 2'b00;
    localparam logic [1:0] PH_NS     = 2'b01;
    localparam logic [1:0] PH_EW     = 2'b10;
    localparam logic [1:0] PH_PED    = 2'b11;

    localparam logic [1:0] REQ_NS  = 2'd0;
    localparam logic [1:0] REQ_EW  = 2'd1;
    localparam logic [1:0] REQ_PED = 2'd2;

    function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
        logic [1:0] idx;
        case (oh)
            3'b010:  idx = REQ_EW;
            3'b100:  idx = REQ_PED;
            default: idx = REQ_NS;
        endcase
        return idx;
    endfunction

    function automatic logic [1:0] idx_to_phase(input logic [1:0] idx);
        logic [1:0] ph;
        case (idx)
            REQ_EW:  ph = PH_EW;
            REQ_PED: ph = PH_PED;
            default: ph = PH_NS;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/phase_scheduler_rr_arbiter3.sv
// Three-way round-robin picker: searches pending starting one past the last
// granted index and returns a one-hot pick. Purely combinational.
module rr_arbiter3
    import phase_sched_pkg::*;
(
    input  logic [2:0] pending,
    input  logic [1:0] last,
    output logic [2:0] pick,
    output logic       valid
);

    logic [1:0] ord0_s;
    logic [1:0] ord1_s;
    logic [1:0] ord2_s;

    // Search order rotated so the most recent winner is examined last.
    always_comb begin
        case (last)
            REQ_NS: begin
                ord0_s = REQ_EW;
                ord1_s = REQ_PED;
                ord2_s = REQ_NS;
            end
            REQ_EW: begin
                ord0_s = REQ_PED;
                ord1_s = REQ_NS;
                ord2_s = REQ_EW;
            end
            default: begin
                ord0_s = REQ_NS;
                ord1_s = REQ_EW;
                ord2_s = REQ_PED;
            end
        endcase
    end

    // First pending requester in rotated order wins.
    always_comb begin
        pick  = 3'b000;
        valid = |pending;
        if (pending[ord0_s]) begin
            pick[ord0_s] = 1'b1;
        end else if (pending[ord1_s]) begin
            pick[ord1_s] = 1'b1;
        end else if (pending[ord2_s]) begin
            pick[ord2_s] = 1'b1;
        end else begin
            pick = 3'b000;
        end
    end

endmodule

// File: rtl/phase_scheduler.sv
// Traffic phase scheduler: latches requests, arbitrates round-robin and issues
// one phase at a time. Optional all-red clearance via PHASE_SCHED_ALL_RED_EN.
module phase_scheduler
    import phase_sched_pkg::*;
#(
    parameter int unsigned CLEAR_CYCLES = 4,
    parameter logic [1:0]  IDLE_PHASE   = PH_NORMAL
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       done,
    output logic [1:0] phase,
    output logic       start,
    output logic [2:0] grant,
    output logic [2:0] pending,
    output logic       busy,
    output logic       all_red
);

    if ((CLEAR_CYCLES < 32'd1) || (CLEAR_CYCLES > 32'd15)) begin : g_bad_clear_cycles
        $error("phase_scheduler: CLEAR_CYCLES must be within 1..15");
    end

    state_e     state_q,   state_d;
    logic [2:0] pending_q, pending_d;
    logic [2:0] grant_q,   grant_d;
    logic [1:0] phase_q,   phase_d;
    logic       start_q,   start_d;
    logic       busy_q,    busy_d;
    logic [1:0] last_q,    last_d;

    logic [2:0] arb_pick_s;
    logic       arb_valid_s;
    logic [1:0] pick_idx_s;

`ifdef PHASE_SCHED_ALL_RED_EN
    localparam logic [3:0] CLR_LOAD = 4'(CLEAR_CYCLES - 32'd1);
    logic [3:0] clr_cnt_q, clr_cnt_d;
    logic       all_red_q, all_red_d;
`endif

    rr_arbiter3 u_arb (
        .pending (pending_q),
        .last    (last_q),
        .pick    (arb_pick_s),
        .valid   (arb_valid_s)
    );

    assign pick_idx_s = onehot_to_idx(arb_pick_s);

    // Next-state and next-output computation for the scheduler FSM.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | req;
        grant_d   = grant_q;
        phase_d   = phase_q;
        start_d   = 1'b0;
        busy_d    = busy_q;
        last_d    = last_q;
`ifdef PHASE_SCHED_ALL_RED_EN
        clr_cnt_d = clr_cnt_q;
        all_red_d = all_red_q;
`endif
        case (state_q)
            ST_IDLE: begin
                phase_d = IDLE_PHASE;
                if (pending_q != 3'b000) begin
                    state_d = ST_ARB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (arb_valid_s) begin
                    state_d   = ST_ISSUE;
                    grant_d   = arb_pick_s;
                    phase_d   = idx_to_phase(pick_idx_s);
                    start_d   = 1'b1;
                    busy_d    = 1'b1;
                    last_d    = pick_idx_s;
                    // The edge entering ISSUE clears the winner even if it re-requests now.
                    pending_d = (pending_q | req) & ~arb_pick_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (done) begin
                    grant_d = 3'b000;
                    phase_d = IDLE_PHASE;
                    busy_d  = 1'b0;
`ifdef PHASE_SCHED_ALL_RED_EN
                    state_d   = ST_CLEAR;
                    all_red_d = 1'b1;
                    clr_cnt_d = CLR_LOAD;
`else
                    state_d = ST_ARB;
`endif
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
`ifdef PHASE_SCHED_ALL_RED_EN
            ST_CLEAR: begin
                if (clr_cnt_q == 4'd0) begin
                    state_d   = ST_ARB;
                    all_red_d = 1'b0;
                end else begin
                    clr_cnt_d = clr_cnt_q - 4'd1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                grant_d = 3'b000;
                phase_d = IDLE_PHASE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered-output flops; reset abandons any phase in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pending_q <= 3'b000;
            grant_q   <= 3'b000;
            phase_q   <= IDLE_PHASE;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            last_q    <= REQ_PED;
`ifdef PHASE_SCHED_ALL_RED_EN
            clr_cnt_q <= 4'd0;
            all_red_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            phase_q   <= phase_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            last_q    <= last_d;
`ifdef PHASE_SCHED_ALL_RED_EN
            clr_cnt_q <= clr_cnt_d;
            all_red_q <= all_red_d;
`endif
        end
    end

    assign phase   = phase_q;
    assign start   = start_q;
    assign grant   = grant_q;
    assign pending = pending_q;
    assign busy    = busy_q;
`ifdef PHASE_SCHED_ALL_RED_EN
    assign all_red = all_red_q;
`else
    assign all_red = 1'b0;
`endif

endmodule
